// File: rtl/cache_arb_pkg.sv
// cache_arb_pkg: shared constants, state encoding and owner helper for the cache/memory arbiter
package cache_arb_pkg;
  localparam int BLK_OFF_W = 4;
  localparam int WORD_IDX_W = 3;
  localparam logic [2:0] ST_HOLD = 3'd0;
  localparam logic [2:0] ST_IDLE = 3'd1;
  localparam logic [2:0] ST_D_WR = 3'd2;
  localparam logic [2:0] ST_D_FILL = 3'd3;
  localparam logic [2:0] ST_I_FILL = 3'd4;
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;
  function automatic logic owner_of(input logic [2:0] s);
    return (s == ST_D_WR || s == ST_D_FILL) ? OWN_D : OWN_I;
  endfunction
endpackage

// File: rtl/arb_burst_tracker.sv
// arb_burst_tracker: burst issue/receive word counters and post-reset hold-off counter
// Ports: i_fill (in a fill state), i_hold (in HOLD), i_rx (accepted read word);
//        o_issue_en/o_issue_idx (next read to issue), o_recv_idx (index of arriving word),
//        o_hold_done (last hold-off cycle), o_burst_done (last word arriving this cycle).
module arb_burst_tracker
  import cache_arb_pkg::*;
#(
  parameter int WORDS_PER_BLK = 8,
  parameter int MEM_LAT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_fill,
  input  logic                  i_hold,
  input  logic                  i_rx,
  output logic                  o_issue_en,
  output logic [WORD_IDX_W-1:0] o_issue_idx,
  output logic [WORD_IDX_W-1:0] o_recv_idx,
  output logic                  o_hold_done,
  output logic                  o_burst_done
);
  localparam int HW = $clog2(MEM_LAT + 1);
  logic [WORD_IDX_W:0]   r_issue;
  logic [WORD_IDX_W-1:0] r_recv;
  logic [HW-1:0]         r_hold;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_issue <= '0;
      r_recv <= '0;
      r_hold <= '0;
    end else begin
      r_issue <= !i_fill ? '0 : o_issue_en ? r_issue + 1'b1 : r_issue;
      r_recv <= !i_fill ? '0 : i_rx ? r_recv + 1'b1 : r_recv;
      r_hold <= (i_hold && !o_hold_done) ? r_hold + 1'b1 : r_hold;
    end
  end
  assign o_issue_en = r_issue < (WORD_IDX_W + 1)'(WORDS_PER_BLK);
  assign o_issue_idx = r_issue[WORD_IDX_W-1:0];
  assign o_recv_idx = r_recv;
  assign o_hold_done = r_hold == HW'(MEM_LAT - 1);
  assign o_burst_done = i_rx && r_recv == WORD_IDX_W'(WORDS_PER_BLK - 1);
endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one multi-cycle memory between I-cache refills and D-cache refills/writes
// Ports: I side i_req/i_addr -> i_fill_vld/i_done; D side d_req/d_wr/d_addr/d_wdata -> d_fill_vld/d_done;
//        shared fill_idx/fill_data; memory mem_en/mem_wr/mem_addr/mem_wdata <- mem_rdata/mem_rvalid;
//        busy; perf_i_fill/perf_d_fill/perf_d_wr completion counters.
// Config: define ARB_PERF_CNT_EN for saturating perf counters, otherwise they read 0.
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WORDS_PER_BLK = 8,
  parameter int MEM_LAT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic                  i_fill_vld,
  output logic                  i_done,
  input  logic                  d_req,
  input  logic                  d_wr,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_fill_vld,
  output logic                  d_done,
  output logic [WORD_IDX_W-1:0] fill_idx,
  output logic [DATA_W-1:0]     fill_data,
  output logic                  mem_en,
  output logic                  mem_wr,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  busy,
  output logic [15:0]           perf_i_fill,
  output logic [15:0]           perf_d_fill,
  output logic [15:0]           perf_d_wr
);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << BLK_OFF_W) - 1);
  logic [2:0]            r_state, w_st, w_nxt;
  logic                  r_i_req, r_d_req;
  logic [ADDR_W-1:0]     r_addr;
  logic                  w_fill, w_rx, w_wr, w_issue_en, w_hold_done, w_burst_done;
  logic [WORD_IDX_W-1:0] w_issue_idx, w_recv_idx;
  // Outputs decode from w_st so every output reads as idle while rst is high
  assign w_st = rst ? ST_HOLD : r_state;
  assign w_fill = w_st == ST_D_FILL || w_st == ST_I_FILL;
  assign w_wr = w_st == ST_D_WR;
  assign w_rx = w_fill && mem_rvalid;
  assign w_nxt = r_state == ST_HOLD ? (w_hold_done ? ST_IDLE : ST_HOLD) :
                 r_state == ST_IDLE ? (r_d_req ? (d_wr ? ST_D_WR : ST_D_FILL) :
                                       r_i_req ? ST_I_FILL : ST_IDLE) :
                 r_state == ST_D_WR ? ST_IDLE :
                 w_fill ? (w_burst_done ? ST_IDLE : r_state) : ST_HOLD;
  arb_burst_tracker #(.WORDS_PER_BLK(WORDS_PER_BLK), .MEM_LAT(MEM_LAT)) u_trk (
    .clk(clk), .rst(rst), .i_fill(w_fill), .i_hold(r_state == ST_HOLD), .i_rx(w_rx),
    .o_issue_en(w_issue_en), .o_issue_idx(w_issue_idx), .o_recv_idx(w_recv_idx),
    .o_hold_done(w_hold_done), .o_burst_done(w_burst_done)
  );
  // Registered requests are cleared on done so the level still held in the done cycle
  // cannot re-grant, which also guarantees an idle cycle between transactions
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_HOLD;
      r_i_req <= 1'b0;
      r_d_req <= 1'b0;
      r_addr <= '0;
    end else begin
      r_state <= w_nxt;
      r_i_req <= i_req && !i_done;
      r_d_req <= d_req && !d_done;
      if (r_state == ST_IDLE) r_addr <= r_d_req ? d_addr : i_addr;
    end
  end
  assign mem_en = w_wr || (w_fill && w_issue_en);
  assign mem_wr = w_wr;
  assign mem_addr = w_wr ? d_addr :
                    mem_en ? (r_addr & ~OFF_MASK) | ADDR_W'({w_issue_idx, 1'b0}) : '0;
  assign mem_wdata = w_wr ? d_wdata : '0;
  assign fill_idx = w_rx ? w_recv_idx : '0;
  assign fill_data = w_rx ? mem_rdata : '0;
  assign d_fill_vld = w_rx && owner_of(w_st) == OWN_D;
  assign i_fill_vld = w_rx && owner_of(w_st) == OWN_I;
  assign d_done = w_wr || (w_st == ST_D_FILL && w_burst_done);
  assign i_done = w_st == ST_I_FILL && w_burst_done;
  assign busy = !rst && r_state != ST_IDLE;
`ifdef ARB_PERF_CNT_EN
  logic [15:0] r_pi, r_pd, r_pw;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pi <= '0;
      r_pd <= '0;
      r_pw <= '0;
    end else begin
      r_pi <= r_pi + 16'(i_done && r_pi != 16'hFFFF);
      r_pd <= r_pd + 16'(d_done && !w_wr && r_pd != 16'hFFFF);
      r_pw <= r_pw + 16'(w_wr && r_pw != 16'hFFFF);
    end
  end
  assign perf_i_fill = r_pi;
  assign perf_d_fill = r_pd;
  assign perf_d_wr = r_pw;
`else
  assign perf_i_fill = '0;
  assign perf_d_fill = '0;
  assign perf_d_wr = '0;
`endif
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: scoreboard bench with a fixed-latency memory model for cache_mem_arbiter
module tb_cache_mem_arbiter;
  localparam int LAT = 4;
  typedef struct packed {logic d; logic [2:0] idx; logic [15:0] data;} fill_t;
  logic clk = 0, rst = 1;
  logic i_req = 0, d_req = 0, d_wr = 0, spur = 0;
  logic [15:0] i_addr = 0, d_addr = 0, d_wdata = 0, mem_base = 0;
  logic i_fill_vld, i_done, d_fill_vld, d_done, mem_en, mem_wr, mem_rvalid, busy;
  logic [2:0] fill_idx;
  logic [15:0] fill_data, mem_addr, mem_wdata, mem_rdata, perf_i_fill, perf_d_fill, perf_d_wr;
  logic pv[LAT] = '{default: 1'b0};
  logic [15:0] pd[LAT] = '{default: 16'h0};
  logic [15:0] q_rd[$];
  logic [31:0] q_wr[$];
  fill_t q_fill[$];
  logic q_done[$];
  fill_t f;
  int total = 0, bad = 0, cyc = 0, t_first = 0, t_done = 0, n_done = 0, n_fill = 0;
  always #5 clk = ~clk;
  cache_mem_arbiter dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .i_fill_vld(i_fill_vld), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_fill_vld(d_fill_vld),
    .d_done(d_done), .fill_idx(fill_idx), .fill_data(fill_data), .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .busy(busy), .perf_i_fill(perf_i_fill), .perf_d_fill(perf_d_fill), .perf_d_wr(perf_d_wr)
  );
  always @(posedge clk) begin
    cyc <= cyc + 1;
    pv[0] <= mem_en && !mem_wr;
    pd[0] <= mem_base + {13'd0, mem_addr[3:1]};
    for (int k = 1; k < LAT; k++) begin
      pv[k] <= pv[k-1];
      pd[k] <= pd[k-1];
    end
  end
  assign mem_rvalid = pv[LAT-1] || spur;
  assign mem_rdata = spur ? 16'h5555 : pd[LAT-1];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: event occurred, none expected", nm);
  endtask
  always @(negedge clk) begin
    if (mem_en && !mem_wr) begin
      if (q_rd.size() == 0) fail("rd_unexp");
      else chk("rd_addr", mem_addr, q_rd.pop_front());
      if (mem_addr[3:1] == 3'd0) t_first = cyc;
    end
    if (mem_en && mem_wr) begin
      if (q_wr.size() == 0) fail("wr_unexp");
      else chk("wr_addr_data", {mem_addr, mem_wdata}, q_wr.pop_front());
      chk("wr_done_same_cycle", d_done, 1);
    end
    if (i_fill_vld || d_fill_vld) begin
      n_fill++;
      if (q_fill.size() == 0) fail("fill_unexp");
      else begin
        f = q_fill.pop_front();
        chk("fill", {d_fill_vld, i_fill_vld, fill_idx, fill_data}, {f.d, ~f.d, f.idx, f.data});
      end
    end
    if (i_done || d_done) begin
      n_done++;
      t_done = cyc;
      if (q_done.size() == 0) fail("done_unexp");
      else chk("done_owner", {d_done, i_done}, q_done.pop_front() ? 2'b10 : 2'b01);
    end
  end
  task automatic push_fill(input logic d, input logic [15:0] addr, input logic [15:0] base);
    fill_t t;
    for (int k = 0; k < 8; k++) begin
      q_rd.push_back({addr[15:4], 3'(k), 1'b0});
      t.d = d;
      t.idx = 3'(k);
      t.data = base + 16'(k);
      q_fill.push_back(t);
    end
    q_done.push_back(d);
  endtask
  task automatic wait_done(input int target, input string nm);
    int n = 0;
    while (n_done < target && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (n_done < target) fail(nm);
  endtask
  task automatic fill_one(input logic d, input logic [15:0] addr, input logic [15:0] base);
    int tgt = n_done + 1;
    push_fill(d, addr, base);
    mem_base = base;
    @(posedge clk); #1;
    if (d) begin d_req = 1; d_wr = 0; d_addr = addr; end
    else begin i_req = 1; i_addr = addr; end
    wait_done(tgt, "fill_timeout");
    #1 i_req = 0; d_req = 0;
    chk("fill_latency", t_done - t_first, 11);
  endtask
  task automatic both_fill(input logic [15:0] da, input logic [15:0] ia, input logic [15:0] base);
    int tgt = n_done + 1, td;
    push_fill(1, da, base);
    push_fill(0, ia, base);
    mem_base = base;
    @(posedge clk); #1;
    d_req = 1; d_wr = 0; d_addr = da; i_req = 1; i_addr = ia;
    wait_done(tgt, "dfirst_timeout");
    #1 d_req = 0;
    td = t_done;
    chk("d_latency", t_done - t_first, 11);
    wait_done(tgt + 1, "ithen_timeout");
    #1 i_req = 0;
    chk("idle_gap", t_first - td, 2);
    chk("i_latency", t_done - t_first, 11);
  endtask
  task automatic write_one(input logic [15:0] a, input logic [15:0] wd);
    int tgt = n_done + 1;
    q_wr.push_back({a, wd});
    q_done.push_back(1);
    @(posedge clk); #1;
    d_req = 1; d_wr = 1; d_addr = a; d_wdata = wd;
    wait_done(tgt, "wr_timeout");
    #1 d_req = 0; d_wr = 0;
  endtask
  task automatic chk_hold();
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk);
      chk("hold_busy", busy, 1);
    end
    @(negedge clk);
    chk("idle_busy", busy, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, tgt;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {mem_en, mem_wr, i_fill_vld, d_fill_vld, i_done, d_done, busy,
                          fill_idx, fill_data, mem_addr, mem_wdata}, 0);
    chk("reset_perf", {perf_i_fill, perf_d_fill, perf_d_wr}, 0);
    @(posedge clk); #1 rst = 0;
    chk_hold();
    fill_one(0, 16'h1234, 16'hA000);
    both_fill(16'h0040, 16'h1234, 16'hB000);
    write_one(16'h0100, 16'hBEEF);
    @(negedge clk);
`ifdef ARB_PERF_CNT_EN
    chk("perf_pre_reset", {perf_i_fill, perf_d_fill, perf_d_wr}, {16'd2, 16'd1, 16'd1});
`else
    chk("perf_pre_reset", {perf_i_fill, perf_d_fill, perf_d_wr}, 0);
`endif
    push_fill(0, 16'h2000, 16'h7000);
    mem_base = 16'h7000;
    tgt = n_fill + 4;
    @(posedge clk); #1 i_req = 1; i_addr = 16'h2000;
    n = 0;
    while (n_fill < tgt && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (n_fill < tgt) fail("rst_wait_timeout");
    #1 rst = 1; i_req = 0;
    q_rd.delete(); q_fill.delete(); q_done.delete();
    @(negedge clk);
    chk("rst_mid_outputs", {mem_en, i_fill_vld, d_fill_vld, i_done, d_done, busy, fill_idx, fill_data}, 0);
    @(posedge clk); #1 rst = 0;
    chk("rst_perf_clear", {perf_i_fill, perf_d_fill, perf_d_wr}, 0);
    chk_hold();
    fill_one(0, 16'h1234, 16'hA000);
    @(posedge clk); #1 spur = 1;
    @(negedge clk);
    chk("spur_no_vld", {i_fill_vld, d_fill_vld, i_done, d_done}, 0);
    chk("spur_busy", busy, 0);
    @(posedge clk); #1 spur = 0;
    @(negedge clk);
    chk("spur_stay_idle", {busy, mem_en}, 0);
    both_fill(16'h0040, 16'h0300, 16'hC000);
    write_one(16'h0100, 16'hBEEF);
    fill_one(1, 16'h0080, 16'h3000);
    fill_one(0, 16'h0500, 16'h4000);
    @(negedge clk);
`ifdef ARB_PERF_CNT_EN
    chk("perf_final", {perf_i_fill, perf_d_fill, perf_d_wr}, {16'd3, 16'd2, 16'd1});
`else
    chk("perf_final", {perf_i_fill, perf_d_fill, perf_d_wr}, 0);
`endif
    repeat (LAT + 2) @(posedge clk);
    chk("queues_drained", q_rd.size() + q_wr.size() + q_fill.size() + q_done.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
